bounded_counter: RTL and testbench

BOUNDED_COUNTER -- requirements
Module: bounded_counter

---
 rtl/bounded_counter_pkg.sv | 21 ++
 rtl/bounded_counter_ch.sv | 91 +++++++++
 rtl/bounded_counter.sv | 43 ++++
 tb/tb_bounded_counter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/bounded_counter_pkg.sv
// Shared types and helpers for the bounded up/down counter.
package bounded_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP     = 2'd0,
    MODE_SATURATE = 2'd1,
    MODE_ONESHOT  = 2'd2,
    MODE_RSVD     = 2'd3
  } mode_e;

  typedef enum logic {
    ST_COUNT = 1'b0,
    ST_DONE  = 1'b1
  } ch_state_e;

  // Reserved mode code behaves exactly like WRAP.
  function automatic logic mode_is_wrap(input mode_e m);
    return (m == MODE_WRAP) || (m == MODE_RSVD);
  endfunction

endpackage

// File: rtl/bounded_counter_ch.sv
// One independent counter channel: clear/load/step priority, terminal handling, oneshot FSM.
module bounded_counter_ch #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_i,
  input  logic             up_dn_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic [WIDTH-1:0] bound_i,
  input  logic [1:0]       mode_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             tc_o,
  output logic             ovf_o,
  output logic             done_o
);
  import bounded_counter_pkg::*;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  ch_state_e        state_q, state_d;
  mode_e            mode;
  logic             term;

  assign mode = mode_e'(mode_i);

  // State register, asynchronously cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= ST_COUNT;
    end else begin
      cnt_q   <= cnt_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  // Next state: clr > load > enabled step in COUNT > hold.
  always_comb begin
    cnt_d   = cnt_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    state_d = state_q;
    term    = 1'b0;
    if (clr_i) begin
      cnt_d   = '0;
      ovf_d   = 1'b0;
      state_d = ST_COUNT;
    end else if (load_i) begin
      cnt_d   = (load_val_i > bound_i) ? bound_i : load_val_i;
      state_d = ST_COUNT;
    end else if (en_i && (state_q == ST_COUNT)) begin
      if (up_dn_i) begin
        if (cnt_q < bound_i) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else begin
          term  = 1'b1;
          // At or above the bound: wrap to zero, otherwise clamp to the bound.
          cnt_d = mode_is_wrap(mode) ? '0 : bound_i;
        end
      end else begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else begin
          term  = 1'b1;
          cnt_d = mode_is_wrap(mode) ? bound_i : '0;
        end
      end
      if (term) begin
        tc_d  = 1'b1;
        ovf_d = 1'b1;
        if (mode == MODE_ONESHOT) begin
          state_d = ST_DONE;
        end
      end
    end
  end

  assign cnt_o  = cnt_q;
  assign tc_o   = tc_q;
  assign ovf_o  = ovf_q;
  assign done_o = (state_q == ST_DONE);

endmodule

// File: rtl/bounded_counter.sv
// Multi-channel bounded counter: NUM_CH independent channels sharing bound, mode and clr.
module bounded_counter #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned NUM_CH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       up_dn,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0]        bound,
  input  logic [1:0]              mode,
  input  logic                    clr,
  output logic [NUM_CH*WIDTH-1:0] out,
  output logic [NUM_CH-1:0]       tc,
  output logic [NUM_CH-1:0]       ovf,
  output logic [NUM_CH-1:0]       done
);
  import bounded_counter_pkg::*;

  // One channel instance per slice of the packed buses.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    bounded_counter_ch #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst),
      .en_i      (en[g]),
      .up_dn_i   (up_dn[g]),
      .load_i    (load[g]),
      .load_val_i(load_val[g*WIDTH +: WIDTH]),
      .bound_i   (bound),
      .mode_i    (mode),
      .clr_i     (clr),
      .cnt_o     (out[g*WIDTH +: WIDTH]),
      .tc_o      (tc[g]),
      .ovf_o     (ovf[g]),
      .done_o    (done[g])
    );
  end

endmodule

// File: tb/tb_bounded_counter.sv
// Bench for bounded_counter: behavioural model compared every cycle plus pinned directed values.
module tb_bounded_counter;
  localparam int W = 4;
  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   en, up_dn, load, tc, ovf, done;
  logic [N*W-1:0] load_val, out;
  logic [W-1:0]   bound;
  logic [1:0]     mode;
  logic           clr;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  int m_cnt [N];
  int m_tc  [N];
  int m_ovf [N];
  int m_done[N];

  bounded_counter #(.WIDTH(W), .NUM_CH(N)) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load),
    .load_val(load_val), .bound(bound), .mode(mode), .clr(clr),
    .out(out), .tc(tc), .ovf(ovf), .done(done)
  );

  always #5 clk = ~clk;

  task automatic expect_eq(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int ch_out(input int ch);
    return int'(out[ch*W +: W]);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < N; c++) begin
      m_cnt[c] = 0; m_tc[c] = 0; m_ovf[c] = 0; m_done[c] = 0;
    end
  endtask

  // Behavioural reference: integer arithmetic straight from the rules.
  task automatic model_step();
    int b, md, v, lv;
    bit wraps, hit;
    b     = int'(bound);
    md    = int'(mode);
    wraps = (md == 0) || (md == 3);
    for (int c = 0; c < N; c++) begin
      m_tc[c] = 0;
      lv = int'(load_val[c*W +: W]);
      v  = m_cnt[c];
      if (clr) begin
        m_cnt[c] = 0; m_ovf[c] = 0; m_done[c] = 0;
      end else if (load[c]) begin
        m_cnt[c]  = (lv < b) ? lv : b;
        m_done[c] = 0;
      end else if (en[c] && m_done[c] == 0) begin
        hit = 1'b0;
        if (up_dn[c]) begin
          if (v < b) v = v + 1;
          else begin hit = 1'b1; v = wraps ? 0 : b; end
        end else begin
          if (v > 0) v = v - 1;
          else begin hit = 1'b1; v = wraps ? b : 0; end
        end
        m_cnt[c] = v;
        if (hit) begin
          m_tc[c]  = 1;
          m_ovf[c] = 1;
          if (md == 2) m_done[c] = 1;
        end
      end
    end
  endtask

  always @(posedge clk) if (rst) model_step();

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int c = 0; c < N; c++) begin
        expect_eq($sformatf("out[%0d]", c), ch_out(c), m_cnt[c]);
        expect_eq($sformatf("tc[%0d]", c), int'(tc[c]), m_tc[c]);
        expect_eq($sformatf("ovf[%0d]", c), int'(ovf[c]), m_ovf[c]);
        expect_eq($sformatf("done[%0d]", c), int'(done[c]), m_done[c]);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    en = '0; up_dn = '0; load = '0; load_val = '0; bound = '0; mode = 2'd0; clr = 1'b0;
    rst = 1'b1;
    model_reset();
    #1 rst = 1'b0;
    tick(2);
    expect_eq("reset_out", int'(out), 0);
    expect_eq("reset_flags", int'({tc, ovf, done}), 0);
    rst = 1'b1;
    chk_en = 1'b1;

    // Wrap up to bound 14 on ch0; ch1 idle.
    mode = 2'd0; bound = 4'd14; up_dn = 2'b01; en = 2'b01;
    tick(14);
    expect_eq("wrap_out14", ch_out(0), 14);
    expect_eq("wrap_tc_pre", int'(tc[0]), 0);
    tick(1);
    expect_eq("wrap_out0", ch_out(0), 0);
    expect_eq("wrap_tc", int'(tc[0]), 1);
    expect_eq("wrap_ovf", int'(ovf[0]), 1);
    expect_eq("wrap_ch1_idle", ch_out(1), 0);
    tick(1);
    expect_eq("wrap_tc_once", int'(tc[0]), 0);
    en = 2'b00;

    // Saturate down on ch1 from a load of 3.
    mode = 2'd1; bound = 4'd5; load_val = {4'd3, 4'd0}; load = 2'b10;
    tick(1);
    expect_eq("sat_load", ch_out(1), 3);
    load = 2'b00; up_dn = 2'b00; en = 2'b10;
    tick(3);
    expect_eq("sat_reach0", ch_out(1), 0);
    expect_eq("sat_tc_reach", int'(tc[1]), 0);
    tick(3);
    expect_eq("sat_hold0", ch_out(1), 0);
    expect_eq("sat_tc_held", int'(tc[1]), 1);
    en = 2'b00;

    // Oneshot on ch0, bound 3.
    clr = 1'b1;
    tick(1);
    expect_eq("clr_ovf0", int'(ovf[0]), 0);
    clr = 1'b0; mode = 2'd2; bound = 4'd3; up_dn = 2'b01; en = 2'b01;
    tick(3);
    expect_eq("os_out3", ch_out(0), 3);
    expect_eq("os_not_done", int'(done[0]), 0);
    tick(1);
    expect_eq("os_done", int'(done[0]), 1);
    expect_eq("os_tc", int'(tc[0]), 1);
    tick(2);
    expect_eq("os_hold", ch_out(0), 3);
    mode = 2'd0;
    tick(2);
    expect_eq("os_mode_stays", int'(done[0]), 1);
    load_val = {4'd0, 4'd9}; load = 2'b01;
    tick(1);
    expect_eq("os_load_clamp", ch_out(0), 3);
    expect_eq("os_load_exit", int'(done[0]), 0);
    load = 2'b00; en = 2'b00;

    // clr beats load and en.
    mode = 2'd0; bound = 4'd15; en = 2'b11; up_dn = 2'b11;
    tick(3);
    clr = 1'b1; load = 2'b11; load_val = 8'hAA;
    tick(1);
    expect_eq("clr_over_load", int'(out), 0);
    expect_eq("clr_ovf", int'(ovf), 0);
    clr = 1'b0; load = 2'b00; en = 2'b00;

    // Async reset mid-count.
    en = 2'b01; up_dn = 2'b01;
    tick(7);
    expect_eq("pre_rst", ch_out(0), 7);
    #2 rst = 1'b0;
    model_reset();
    #1;
    expect_eq("async_rst_out", int'(out), 0);
    expect_eq("async_rst_flags", int'({ovf, done}), 0);
    tick(1);
    rst = 1'b1;
    tick(1);
    expect_eq("resume1", ch_out(0), 1);
    tick(1);
    expect_eq("resume2", ch_out(0), 2);
    en = 2'b00;

    // Bound lowered below the count.
    load_val = {4'd0, 4'd10}; load = 2'b01;
    tick(1);
    load = 2'b00; bound = 4'd4; en = 2'b01;
    tick(1);
    expect_eq("lower_wrap", ch_out(0), 0);
    expect_eq("lower_wrap_tc", int'(tc[0]), 1);
    en = 2'b00; bound = 4'd15; load = 2'b01;
    tick(1);
    load = 2'b00; mode = 2'd1; bound = 4'd4; en = 2'b01;
    tick(1);
    expect_eq("lower_sat", ch_out(0), 4);
    expect_eq("lower_sat_tc", int'(tc[0]), 1);
    tick(1);
    expect_eq("sat_repeat_tc", int'(tc[0]), 1);

    // bound=0 and full-range down wrap.
    mode = 2'd0; bound = 4'd0; en = 2'b11; up_dn = 2'b11;
    tick(2);
    expect_eq("b0_out", ch_out(0), 0);
    expect_eq("b0_tc", int'(tc[0]), 1);
    clr = 1'b1; en = 2'b00;
    tick(1);
    clr = 1'b0; bound = 4'd15; up_dn = 2'b00; en = 2'b01;
    tick(1);
    expect_eq("full_down_wrap", ch_out(0), 15);
    expect_eq("full_down_tc", int'(tc[0]), 1);

    // Mixed vectors, checked by the model only.
    for (int i = 0; i < 80; i++) begin
      en       = N'($urandom);
      up_dn    = N'($urandom);
      load     = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      load_val = (N*W)'($urandom);
      if ($urandom_range(0, 9) == 0) bound = W'($urandom);
      if ($urandom_range(0, 9) == 0) mode = 2'($urandom);
      clr      = ($urandom_range(0, 24) == 0);
      tick(1);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
